bsg_wormhole_multicast: RTL and testbench

Single-input, `els_p`-output wormhole multicast splitter for the NoC. It generalises the two-way local/pass-through broadcast to `els_p` outputs selected by a per-packet destination mask, and adds packet drop when the mask is zero. It sits between a link input and a set of consumers (local endpoint, neighbour links), with zero-latency ready/valid forwarding. Each output may stall independently without duplicating or losing flits.

---
 rtl/bsg_wormhole_multicast_pkg.sv | 15 +
 rtl/bsg_wormhole_multicast_if.sv | 22 ++
 rtl/bsg_wormhole_multicast_tracker.sv | 33 +++
 rtl/bsg_wormhole_multicast.sv | 75 +++++++
 tb/tb_bsg_wormhole_multicast.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_wormhole_multicast_pkg.sv
// rtl/bsg_wormhole_multicast_pkg.sv - shared state enum and header layout for the multicast splitter
`define BSG_WORMHOLE_MULTICAST_HEADER_S(els, len_bits) \
    struct packed { \
        logic [(len_bits)-1:0] payload_len; \
        logic [(els)-1:0]      dest_mask; \
    }

package bsg_wormhole_multicast_pkg;

    typedef enum logic {
        eHeader = 1'b0,
        eBody   = 1'b1
    } state_e;

endpackage

// File: rtl/bsg_wormhole_multicast_if.sv
// rtl/bsg_wormhole_multicast_if.sv - link-side and consumer-side handshake bundle of the splitter
interface bsg_wormhole_multicast_if #(
    parameter int width_p = 32,
    parameter int els_p   = 4
);
    logic                            v_i;
    logic [width_p-1:0]              data_i;
    logic                            ready_and_o;
    logic [els_p-1:0]                v_o;
    logic [els_p-1:0][width_p-1:0]   data_o;
    logic [els_p-1:0]                ready_and_i;

    modport master (
        output v_i, data_i, ready_and_i,
        input  ready_and_o, v_o, data_o
    );

    modport slave (
        input  v_i, data_i, ready_and_i,
        output ready_and_o, v_o, data_o
    );
endinterface

// File: rtl/bsg_wormhole_multicast_tracker.sv
// rtl/bsg_wormhole_multicast_tracker.sv - per-output acceptance record and and-type ready reduction
module bsg_wormhole_multicast_tracker #(
    parameter int els_p = 4
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             v_i,
    input  logic [els_p-1:0] sel_i,
    input  logic [els_p-1:0] ready_and_i,
    output logic [els_p-1:0] v_o,
    output logic             ready_and_o
);
    logic [els_p-1:0] sent_q, sent_d;

    // An output that already took the current flit is masked off so it never sees it twice.
    assign v_o         = {els_p{v_i}} & sel_i & ~sent_q;
    assign ready_and_o = &(~sel_i | sent_q | ready_and_i);

    always_comb begin
        sent_d = sent_q | (v_o & ready_and_i);
        if (v_i && ready_and_o) begin
            sent_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sent_q <= '0;
        end else begin
            sent_q <= sent_d;
        end
    end
endmodule

// File: rtl/bsg_wormhole_multicast.sv
// rtl/bsg_wormhole_multicast.sv - single-input wormhole splitter forwarding each packet to a destination-mask subset
module bsg_wormhole_multicast
    import bsg_wormhole_multicast_pkg::*;
#(
    parameter int width_p            = 32,
    parameter int els_p              = 4,
    parameter int payload_len_bits_p = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    bsg_wormhole_multicast_if.slave  link
);
    localparam int hdr_width_lp = els_p + payload_len_bits_p;

    typedef `BSG_WORMHOLE_MULTICAST_HEADER_S(els_p, payload_len_bits_p) header_s;

    header_s                       hdr;
    state_e                        state_q, state_d;
    logic [els_p-1:0]              sel_q, sel_d, sel;
    logic [payload_len_bits_p-1:0] len_q, len_d;
    logic                          fire;

    assign hdr  = header_s'(link.data_i[hdr_width_lp-1:0]);
    assign sel  = (state_q == eHeader) ? hdr.dest_mask : sel_q;
    assign fire = link.v_i & link.ready_and_o;

    for (genvar k = 0; k < els_p; k++) begin : g_lane
        assign link.data_o[k] = link.data_i;
    end

    bsg_wormhole_multicast_tracker #(
        .els_p (els_p)
    ) tracker (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .v_i         (link.v_i),
        .sel_i       (sel),
        .ready_and_i (link.ready_and_i),
        .v_o         (link.v_o),
        .ready_and_o (link.ready_and_o)
    );

    // A zero mask still walks the length counter so the dropped payload is swallowed whole.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        len_d   = len_q;
        if (fire) begin
            if (state_q == eHeader) begin
                sel_d = hdr.dest_mask;
                len_d = hdr.payload_len;
                if (hdr.payload_len != '0) begin
                    state_d = eBody;
                end
            end else begin
                len_d = len_q - payload_len_bits_p'(1);
                if (len_q == payload_len_bits_p'(1)) begin
                    state_d = eHeader;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= eHeader;
            sel_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            len_q   <= len_d;
        end
    end
endmodule

// File: tb/tb_bsg_wormhole_multicast.sv
// tb/tb_bsg_wormhole_multicast.sv - packet-level scoreboard bench for the multicast splitter
module tb_bsg_wormhole_multicast;
    typedef struct {
        logic [31:0] data;
        logic [3:0]  mask;
    } flit_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bsg_wormhole_multicast_if #(.width_p(32), .els_p(4)) link ();

    bsg_wormhole_multicast #(
        .width_p            (32),
        .els_p              (4),
        .payload_len_bits_p (4)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .link      (link)
    );

    int          vectors = 0;
    int          miscompares = 0;
    flit_t       in_q[$];
    logic [31:0] exp_q[4][$];
    logic [3:0]  acc = 4'h0;
    int          acc_cnt[4];
    int          consumed = 0;
    int          vcycles = 0;
    int          ro_low = 0;
    bit          bubbles = 1'b0;
    logic [31:0] exp_w;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic clr_cnt();
        for (int k = 0; k < 4; k++) acc_cnt[k] = 0;
        consumed = 0;
        vcycles  = 0;
        ro_low   = 0;
    endtask

    task automatic add_pkt(input logic [3:0] mask, input int len, input logic [31:0] base);
        flit_t f;
        logic [31:0] w;
        w = $urandom;
        w[7:4] = 4'(len);
        w[3:0] = mask;
        for (int i = 0; i <= len; i++) begin
            if (i > 0) w = base + 32'(i - 1);
            f.data = w;
            f.mask = mask;
            in_q.push_back(f);
            for (int k = 0; k < 4; k++) if (mask[k]) exp_q[k].push_back(w);
        end
    endtask

    task automatic tick(input logic [3:0] r);
        @(posedge clk);
        #1;
        link.ready_and_i = r;
        if (in_q.size() > 0 && (acc != 4'h0 || !bubbles || $urandom_range(0, 4) != 0)) begin
            link.v_i    = 1'b1;
            link.data_i = in_q[0].data;
        end else begin
            link.v_i    = 1'b0;
            link.data_i = $urandom;
        end
    endtask

    task automatic drain(input int mode, input int budget);
        int c;
        logic [3:0] r;
        c = 0;
        while (in_q.size() > 0 && c < budget) begin
            case (mode)
                0:       r = 4'hF;
                1:       r = {2'b11, c[0], 1'b1};
                default: for (int k = 0; k < 4; k++) r[k] = ($urandom_range(0, 3) != 0);
            endcase
            tick(r);
            c++;
        end
        chk(in_q.size() == 0, "drain_timeout", 64'(in_q.size()), 0);
    endtask

    // Scoreboard: each accepted output flit must be the next one that output is owed.
    always @(negedge clk) begin
        if (rst_n) begin
            if (link.v_i) vcycles++;
            for (int k = 0; k < 4; k++) begin
                if (link.v_o[k]) begin
                    chk(link.v_i, "v_o_without_v_i", 0, 1);
                    if (link.v_i && in_q.size() > 0) begin
                        chk(in_q[0].mask[k], "v_o_unselected", 64'(k), 64'(in_q[0].mask));
                        chk(!acc[k], "duplicate_flit", 64'(k), 0);
                    end
                    chk(link.data_o[k] == link.data_i, "lane_data", link.data_o[k], link.data_i);
                    if (link.ready_and_i[k]) begin
                        acc[k] = 1'b1;
                        acc_cnt[k]++;
                        chk(exp_q[k].size() != 0, "unexpected_flit", 64'(k), 0);
                        if (exp_q[k].size() != 0) begin
                            exp_w = exp_q[k].pop_front();
                            chk(link.data_o[k] == exp_w, "flit_order", link.data_o[k], exp_w);
                        end
                    end
                end
            end
            if (link.ready_and_i == 4'hF) chk(link.ready_and_o, "full_throughput", 0, 1);
            if (link.v_i && in_q.size() > 0) begin
                if (!link.ready_and_o) ro_low++;
                if (link.ready_and_o) begin
                    chk(acc == in_q[0].mask, "consumed_early", acc, in_q[0].mask);
                    void'(in_q.pop_front());
                    acc = 4'h0;
                    consumed++;
                end else begin
                    chk(acc != in_q[0].mask, "stalled_after_all_took", acc, in_q[0].mask);
                end
            end
        end
    end

    initial begin
        link.v_i = 1'b0;
        link.data_i = '0;
        link.ready_and_i = 4'h0;
        clr_cnt();
        #2;
        chk(link.v_o == 4'h0, "reset_v_o", link.v_o, 0);
        chk(link.ready_and_o == 1'b1, "reset_ready_zero_mask", link.ready_and_o, 1);
        link.data_i = 32'h0000_0002;
        #1;
        chk(link.ready_and_o == 1'b0, "reset_ready_mask_stalled", link.ready_and_o, 0);
        link.ready_and_i = 4'b0010;
        #1;
        chk(link.ready_and_o == 1'b1, "reset_ready_mask_ready", link.ready_and_o, 1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Local unicast
        clr_cnt();
        add_pkt(4'b0001, 2, 32'hBEEF_0000);
        drain(0, 20);
        chk(acc_cnt[0] == 3, "unicast_out0", 64'(acc_cnt[0]), 3);
        chk(acc_cnt[1] + acc_cnt[2] + acc_cnt[3] == 0, "unicast_others", 64'(acc_cnt[1] + acc_cnt[2] + acc_cnt[3]), 0);
        chk(vcycles == 3, "unicast_cycles", 64'(vcycles), 3);

        // Broadcast with output 1 toggling
        clr_cnt();
        add_pkt(4'b1111, 2, 32'hBEEF_0002);
        drain(1, 40);
        for (int k = 0; k < 4; k++) chk(acc_cnt[k] == 3, "bcast_count", 64'(acc_cnt[k]), 3);
        chk(ro_low == 3, "bcast_ready_low", 64'(ro_low), 3);
        chk(vcycles == 6, "bcast_cycles", 64'(vcycles), 6);

        // Zero length then another header
        clr_cnt();
        add_pkt(4'b0100, 0, 32'h0);
        add_pkt(4'b0001, 0, 32'h0);
        drain(0, 20);
        chk(acc_cnt[2] == 1 && acc_cnt[0] == 1, "zero_len", 64'(acc_cnt[2] * 16 + acc_cnt[0]), 17);

        // Drop
        clr_cnt();
        add_pkt(4'b0000, 2, 32'hD0D0_0000);
        drain(0, 20);
        chk(consumed == 3, "drop_consumed", 64'(consumed), 3);
        chk(vcycles == 3, "drop_cycles", 64'(vcycles), 3);
        chk(acc_cnt[0] + acc_cnt[1] + acc_cnt[2] + acc_cnt[3] == 0, "drop_no_output", 64'(acc_cnt[0] + acc_cnt[1] + acc_cnt[2] + acc_cnt[3]), 0);

        // Maximum length
        clr_cnt();
        add_pkt(4'b0010, 15, 32'hA000_0000);
        add_pkt(4'b0100, 0, 32'h0);
        drain(0, 40);
        chk(acc_cnt[1] == 16, "maxlen_out1", 64'(acc_cnt[1]), 16);
        chk(acc_cnt[2] == 1, "maxlen_next_header", 64'(acc_cnt[2]), 1);

        // Partial acceptance ordering
        clr_cnt();
        add_pkt(4'b0011, 0, 32'h0);
        for (int i = 0; i < 5; i++) tick(4'b0001);
        @(negedge clk);
        #1;
        chk(acc_cnt[0] == 1, "partial_out0_once", 64'(acc_cnt[0]), 1);
        chk(consumed == 0, "partial_held", 64'(consumed), 0);
        drain(0, 20);
        chk(consumed == 1 && acc_cnt[1] == 1 && acc_cnt[0] == 1, "partial_complete", 64'(consumed), 1);

        // Reset mid-packet with output 0 already holding a partial acceptance
        clr_cnt();
        add_pkt(4'b0011, 3, 32'hBEEF_0010);
        tick(4'hF);
        tick(4'hF);
        tick(4'b0001);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        link.v_i = 1'b0;
        #1;
        chk(link.v_o == 4'h0, "reset_mid_v_o", link.v_o, 0);
        in_q.delete();
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        acc = 4'h0;
        clr_cnt();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        add_pkt(4'b1000, 1, 32'hC000_0000);
        add_pkt(4'b0001, 0, 32'h0);
        drain(0, 20);
        chk(acc_cnt[3] == 2, "post_reset_out3", 64'(acc_cnt[3]), 2);
        chk(acc_cnt[0] == 1 && acc_cnt[1] == 0 && acc_cnt[2] == 0, "post_reset_others", 64'(acc_cnt[0]), 1);

        // Randomized traffic
        bubbles = 1'b1;
        for (int p = 0; p < 200; p++) add_pkt(4'($urandom_range(0, 15)), $urandom_range(0, 15), $urandom);
        drain(2, 20000);
        bubbles = 1'b0;
        tick(4'hF);

        for (int k = 0; k < 4; k++) chk(exp_q[k].size() == 0, "owed_flits_left", 64'(exp_q[k].size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
